// File: rtl/testboard_sequencer.sv
// -----------------------------------------------------------------------------
// testboard_sequencer
//
// Sweeps a stimulus vector over a bank of gates under test. Each vector is
// applied, allowed to settle, then every gate output is compared with its
// golden value. Mismatches are recorded per channel (sticky) and counted per
// vector (saturating).
//
// Ports
//   clk_i       single clock
//   rst_ni      asynchronous active-low reset
//   start_i     asynchronous start switch; a rising edge starts a sweep
//   loop_i      at the last vector: 1 = restart the sweep, 0 = finish
//   result_i    asynchronous gate outputs under test (NUM_CH bits)
//   golden_i    expected outputs for the current stim_o (NUM_CH bits)
//   stim_o      registered stimulus vector (IN_W bits)
//   err_o       sticky per-channel mismatch flags
//   fail_cnt_o  saturating count of vectors with at least one mismatch
//   busy_o      sweep in progress
//   done_o      sweep finished, results held
//   pass_o      finished with no channel in error
//   led_o       live gate outputs while idle/busy, error flags when done
// -----------------------------------------------------------------------------
module testboard_sequencer #(
   parameter int                NUM_CH     = 16,
   parameter int                IN_W       = 3,
   parameter int                SETTLE_CYC = 4,
   parameter logic [NUM_CH-1:0] CH_MASK    = '1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              loop_i,
   input  logic [NUM_CH-1:0] result_i,
   input  logic [NUM_CH-1:0] golden_i,
   output logic [IN_W-1:0]   stim_o,
   output logic [NUM_CH-1:0] err_o,
   output logic [7:0]        fail_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [NUM_CH-1:0] led_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [IN_W-1:0] VEC_MAX   = '1;
   localparam logic [7:0]      SETTLE_LD = 8'(SETTLE_CYC);

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_start_s1;
   logic                r_start_s2;
   logic                r_start_q;
   logic [1:0]          r_prime;
   logic [NUM_CH-1:0]   r_res_s1;
   logic [NUM_CH-1:0]   r_res_s2;

   logic [IN_W-1:0]     r_vec;
   logic [7:0]          r_settle;
   logic [IN_W-1:0]     r_stim;
   logic [NUM_CH-1:0]   r_err;
   logic [7:0]          r_fail;

   logic                w_start_evt;
   logic                w_last;
   logic [NUM_CH-1:0]   w_mismatch;

   // -------------------------------------------------------------------------
   // Input synchronisers and start edge detection
   // -------------------------------------------------------------------------
   // r_prime fills with ones over the first two clocks after reset, i.e. once
   // the synchroniser holds a genuinely sampled value. Until then the edge
   // reference r_start_q is held at 1, so a start switch that is already high
   // at reset release is not seen as a fresh edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_start_s1 <= 1'b0;
         r_start_s2 <= 1'b0;
         r_start_q  <= 1'b1;
         r_prime    <= 2'b00;
         r_res_s1   <= '0;
         r_res_s2   <= '0;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments so every
         // flop samples the pre-edge value, independent of statement order.
         r_start_s1 <= start_i;
         r_start_s2 <= r_start_s1;
         r_prime    <= {r_prime[0], 1'b1};
         r_start_q  <= r_prime[1] ? r_start_s2 : 1'b1;
         r_res_s1   <= result_i;
         r_res_s2   <= r_res_s1;
      end
   end

   assign w_start_evt = r_prime[1] & r_start_s2 & ~r_start_q;
   assign w_last      = (r_vec == VEC_MAX);
   assign w_mismatch  = (r_res_s2 ^ golden_i) & CH_MASK;

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves the signal
      // unassigned and infers a latch.
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE,
         ST_DONE:   if (w_start_evt) w_state_nxt = ST_APPLY;
         ST_APPLY:  w_state_nxt = ST_SETTLE;
         // Counter is loaded with SETTLE_CYC in APPLY, so leaving when it
         // reads 1 gives exactly SETTLE_CYC cycles here.
         ST_SETTLE: if (r_settle == 8'd1) w_state_nxt = ST_CHECK;
         ST_CHECK:  w_state_nxt = (!w_last || loop_i) ? ST_APPLY : ST_DONE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: vector/settle counters, stimulus, error flags, fail count
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vec    <= '0;
         r_settle <= '0;
         r_stim   <= '0;
         r_err    <= '0;
         r_fail   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE,
            ST_DONE: begin
               if (w_start_evt) begin
                  r_vec  <= '0;
                  r_err  <= '0;
                  r_fail <= '0;
               end
            end
            ST_APPLY: begin
               r_stim   <= r_vec;
               r_settle <= SETTLE_LD;
            end
            ST_SETTLE: r_settle <= r_settle - 8'd1;
            ST_CHECK: begin
               r_err <= r_err | w_mismatch;
               if ((|w_mismatch) && (r_fail != 8'hFF)) r_fail <= r_fail + 8'd1;
               r_vec <= w_last ? '0 : r_vec + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign stim_o     = r_stim;
   assign err_o      = r_err;
   assign fail_cnt_o = r_fail;
   assign busy_o     = (r_state == ST_APPLY) || (r_state == ST_SETTLE) ||
                       (r_state == ST_CHECK);
   assign done_o     = (r_state == ST_DONE);
   assign pass_o     = done_o && (r_err == '0);
   assign led_o      = done_o ? r_err : r_res_s2;

endmodule

// File: tb/tb_testboard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_testboard_sequencer
//
// Drives two sequencers (full mask and a mask excluding channel 5) from one
// set of gate tables: golden_i = gold[stim], result_i = gold[stim] ^ fault[stim].
// Expected results are derived from the fault table: error flags are the OR of
// masked faults, the fail count is the number of faulty vectors times the
// number of passes, capped at 255, and timing follows 6 cycles per vector.
// -----------------------------------------------------------------------------
module tb_testboard_sequencer;

   localparam int NV       = 8;
   localparam int PER_VEC  = 6;
   localparam int PER_PASS = NV * PER_VEC;
   localparam logic [15:0] MASK_ALL = 16'hFFFF;
   localparam logic [15:0] MASK_M   = 16'hFFDF;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic        loop_i;
   logic [15:0] result_i;
   logic [15:0] golden_i;

   logic [2:0]  stim_o,  stim_m;
   logic [15:0] err_o,   err_m;
   logic [7:0]  fail_o,  fail_m;
   logic        busy_o,  busy_m;
   logic        done_o,  done_m;
   logic        pass_o,  pass_m;
   logic [15:0] led_o,   led_m;

   logic [15:0] gold_tbl  [NV];
   logic [15:0] fault_tbl [NV];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   assign golden_i = gold_tbl[stim_o];
   assign result_i = gold_tbl[stim_o] ^ fault_tbl[stim_o];

   testboard_sequencer u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .loop_i(loop_i),
      .result_i(result_i), .golden_i(golden_i), .stim_o(stim_o),
      .err_o(err_o), .fail_cnt_o(fail_o), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .led_o(led_o)
   );

   testboard_sequencer #(.CH_MASK(MASK_M)) u_dut_m (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .loop_i(loop_i),
      .result_i(result_i), .golden_i(golden_i), .stim_o(stim_m),
      .err_o(err_m), .fail_cnt_o(fail_m), .busy_o(busy_m), .done_o(done_m),
      .pass_o(pass_m), .led_o(led_m)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_err(input logic [15:0] mask);
      logic [15:0] e;
      e = '0;
      for (int v = 0; v < NV; v++) e |= fault_tbl[v] & mask;
      return e;
   endfunction

   function automatic int exp_fail(input logic [15:0] mask, input int passes);
      int n;
      n = 0;
      for (int v = 0; v < NV; v++) if ((fault_tbl[v] & mask) != 0) n++;
      n = n * passes;
      return (n > 255) ? 255 : n;
   endfunction

   task automatic new_gold();
      for (int v = 0; v < NV; v++) gold_tbl[v] = 16'($urandom);
   endtask

   // Starts a sweep and follows it to DONE. loop_i, if set by the caller, is
   // dropped part-way into the final pass. poke pulses start mid-sweep.
   task automatic run_sweep(input int n_passes, input bit poke);
      bit seen;
      int k;
      logic [15:0] e_all, e_m;
      start_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk_i);
         if (busy_o) seen = 1'b1;
      end
      start_i = 1'b0;
      check("busy_rise", 32'(seen), 32'd1);
      if (!seen) return;
      check("clr_err",  32'(err_o),  32'd0);
      check("clr_fail", 32'(fail_o), 32'd0);
      k = 0;
      while (busy_o && k < n_passes * PER_PASS + 20) begin
         if (k % PER_VEC == 3)
            check("stim_step", 32'(stim_o), 32'((k / PER_VEC) % NV));
         if (k % PER_VEC == PER_VEC - 1)
            check("led_busy", 32'(led_o),
                  32'(gold_tbl[(k / PER_VEC) % NV] ^ fault_tbl[(k / PER_VEC) % NV]));
         if (poke && k == 20) start_i = 1'b1;
         if (poke && k == 24) start_i = 1'b0;
         if (loop_i && k == (n_passes - 1) * PER_PASS + 10) loop_i = 1'b0;
         k++;
         @(negedge clk_i);
      end
      e_all = exp_err(MASK_ALL);
      e_m   = exp_err(MASK_M);
      check("busy_len",  32'(k), 32'(n_passes * PER_PASS));
      check("done",      32'(done_o), 32'd1);
      check("stim_last", 32'(stim_o), 32'(NV - 1));
      check("err",       32'(err_o),  32'(e_all));
      check("fail_cnt",  32'(fail_o), 32'(exp_fail(MASK_ALL, n_passes)));
      check("pass",      32'(pass_o), 32'(e_all == 0));
      check("led_done",  32'(led_o),  32'(e_all));
      check("m_done",    32'(done_m), 32'd1);
      check("m_err",     32'(err_m),  32'(e_m));
      check("m_fail",    32'(fail_m), 32'(exp_fail(MASK_M, n_passes)));
      check("m_pass",    32'(pass_m), 32'(e_m == 0));
      check("m_led",     32'(led_m),  32'(e_m));
      repeat (3) @(negedge clk_i);
      check("done_hold", 32'(done_o), 32'd1);
      check("err_hold",  32'(err_o),  32'(e_all));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst_ni  = 1'b0;
      start_i = 1'b0;
      loop_i  = 1'b0;
      for (int v = 0; v < NV; v++) begin
         gold_tbl[v]  = '0;
         fault_tbl[v] = '0;
      end
      repeat (2) @(negedge clk_i);
      check("rst_stim", 32'(stim_o), 32'd0);
      check("rst_err",  32'(err_o),  32'd0);
      check("rst_fail", 32'(fail_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_pass", 32'(pass_o), 32'd0);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk_i);
      check("idle_busy", 32'(busy_o), 32'd0);

      // Clean sweep: every channel matches.
      new_gold();
      run_sweep(1, 1'b0);

      // Channel 5 inverted on vector 3 only; a start pulse mid-sweep is ignored.
      new_gold();
      fault_tbl[3] = 16'h0020;
      run_sweep(1, 1'b1);

      // Random fault patterns, some vectors clean, some channel-5-only.
      for (int r = 0; r < 4; r++) begin
         new_gold();
         for (int v = 0; v < NV; v++) begin
            case ($urandom_range(0, 3))
               0, 1:    fault_tbl[v] = '0;
               2:       fault_tbl[v] = 16'h0020;
               default: fault_tbl[v] = 16'($urandom);
            endcase
         end
         run_sweep(1, r[0]);
      end

      // Loop mode with every vector failing: count saturates at 255.
      new_gold();
      for (int v = 0; v < NV; v++) fault_tbl[v] = 16'($urandom) | 16'h0001;
      loop_i = 1'b1;
      run_sweep(34, 1'b0);

      // Reset during SETTLE of vector 4 with start held high.
      new_gold();
      start_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk_i);
         if (busy_o) seen = 1'b1;
      end
      check("rst_busy_rise", 32'(seen), 32'd1);
      repeat (4 * PER_VEC + 2) @(negedge clk_i);
      check("rst_pre_stim", 32'(stim_o), 32'd4);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_stim", 32'(stim_o), 32'd0);
      check("mid_rst_err",  32'(err_o),  32'd0);
      check("mid_rst_fail", 32'(fail_o), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_done", 32'(done_o), 32'd0);
      check("mid_rst_pass", 32'(pass_o), 32'd0);
      check("mid_rst_led",  32'(led_o),  32'd0);
      check("mid_rst_m",    32'({stim_m, busy_m}), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (30) @(negedge clk_i);
      check("held_start_busy", 32'(busy_o), 32'd0);
      check("held_start_done", 32'(done_o), 32'd0);
      check("held_start_stim", 32'(stim_o), 32'd0);
      start_i = 1'b0;
      repeat (6) @(negedge clk_i);

      // Fresh start after reset runs a normal sweep.
      for (int v = 0; v < NV; v++) fault_tbl[v] = (v == 6) ? 16'h8001 : 16'h0000;
      run_sweep(1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/testboard_sequencer.md
TESTBOARD_SEQUENCER -- requirements
Module: testboard_sequencer

Interface
REQ-001 Parameter NUM_CH, default 16, number of gate channels under test; legal range 1..32.
REQ-002 Parameter IN_W, default 3, stimulus width; vectors swept 0..2^IN_W-1; legal range 1..8.
REQ-003 Parameter SETTLE_CYC, default 4, wait cycles per vector after stimulus change; legal range 3..255.
REQ-004 Parameter CH_MASK, default all ones (NUM_CH bits), channels with bit 0 excluded from comparison.
REQ-005 Port clk_i, input, 1, single clock for the whole block.
REQ-006 Port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 Port start_i, input, 1, asynchronous start switch; active high.
REQ-008 Port loop_i, input, 1, sampled in CHECK; 1 = restart sweep after last vector.
REQ-009 Port result_i, input, NUM_CH, asynchronous gate outputs under test.
REQ-010 Port golden_i, input, NUM_CH, expected outputs for current stim_o; combinational from stim_o.
REQ-011 Port stim_o, output, IN_W, registered stimulus vector driven to all gates.
REQ-012 Port err_o, output, NUM_CH, sticky per-channel mismatch flags.
REQ-013 Port fail_cnt_o, output, 8, saturating count of vectors with at least one mismatch.
REQ-014 Port busy_o, output, 1, high in APPLY, SETTLE and CHECK.
REQ-015 Port done_o, output, 1, high in DONE.
REQ-016 Port pass_o, output, 1, high when done_o=1 and err_o=0.
REQ-017 Port led_o, output, NUM_CH, LED drive.

Function
REQ-018 start_i and result_i shall each pass through a 2-flop synchroniser; all other logic uses the synchronised copies.
REQ-019 A start event is a 0->1 transition of synchronised start_i; it is acted on only in IDLE or DONE and ignored in all other states.
REQ-020 FSM states: IDLE, APPLY, SETTLE, CHECK, DONE; reset state IDLE.
REQ-021 IDLE/DONE + start event -> APPLY; same cycle: err_o=0, fail_cnt_o=0, vector counter=0.
REQ-022 APPLY, one cycle: stim_o <= vector counter; settle counter loaded with SETTLE_CYC; -> SETTLE.
REQ-023 SETTLE: settle counter decrements each cycle; on reaching 0 -> CHECK; exactly SETTLE_CYC cycles spent in SETTLE.
REQ-024 CHECK, one cycle: mismatch = (sync result ^ golden_i) & CH_MASK; err_o <= err_o | mismatch; if mismatch != 0, fail_cnt_o increments, saturating at 255.
REQ-025 CHECK, vector != 2^IN_W-1: vector counter increments -> APPLY.
REQ-026 CHECK, vector == 2^IN_W-1, loop_i=1: vector counter wraps to 0, err_o and fail_cnt_o retained -> APPLY.
REQ-027 CHECK, vector == 2^IN_W-1, loop_i=0 -> DONE.
REQ-028 Per-vector latency APPLY to CHECK inclusive = SETTLE_CYC+2 cycles; one-shot sweep from start event to done_o=1 = 2^IN_W*(SETTLE_CYC+2)+1 cycles.
REQ-029 DONE holds stim_o, err_o, fail_cnt_o until a start event or reset.
REQ-030 led_o = synchronised result_i in IDLE; = synchronised result_i while busy_o=1; = err_o in DONE.
REQ-031 Deasserting loop_i mid-sweep takes effect at the next last-vector CHECK; no abort path exists other than reset.

Reset
REQ-032 rst_ni low shall immediately force: state IDLE, stim_o=0, err_o=0, fail_cnt_o=0, busy_o=0, done_o=0, pass_o=0, both synchroniser chains 0, vector and settle counters 0.
REQ-033 Reset asserted mid-sweep shall discard all progress; after release the block stays in IDLE until a fresh start event.
REQ-034 A start_i held high through reset release shall not produce a start event until it goes low then high again.

Verification
REQ-035 Defaults, golden_i=result_i, start pulse, loop_i=0 -> stim_o steps 0..7, done_o after 8*6+1 cycles, pass_o=1, fail_cnt_o=0, led_o=0.
REQ-036 Channel 5 forced inverted for vector 3 only -> err_o=16'h0020, fail_cnt_o=1, pass_o=0, led_o=16'h0020 in DONE.
REQ-037 CH_MASK=16'hFFDF, same fault as REQ-036 -> err_o=0, pass_o=1.
REQ-038 loop_i=1, all channels mismatching -> stim_o wraps 7->0, fail_cnt_o reaches 255 and holds; loop_i=0 -> DONE at next vector 7.
REQ-039 Second start pulse while busy_o=1 -> ignored, sweep timing unchanged; start in DONE -> err_o and fail_cnt_o cleared, new sweep.
REQ-040 rst_ni pulsed low at vector 4 during SETTLE -> all outputs 0 immediately; held-high start_i does not restart.
